// File: rtl/regfile_mp_pkg.sv
// Shared datapath constants and helpers used by the register file and its neighbours.
// Default widths live here so every datapath block agrees on them.
package regfile_mp_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;

  // Address width for a power-of-two register count (ceil(log2(n))).
  function automatic int aw_of(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, two write ports, reserve.
// The master drives addresses and write data; the register file is the slave.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2
);
  localparam int AW = aw_of(NREG);

  logic [NRD*AW-1:0]   RA;
  logic [NRD*XLEN-1:0] DO;
  logic [NRD-1:0]      BUSY;
  logic                WE0;
  logic                WE1;
  logic [AW-1:0]       RW0;
  logic [AW-1:0]       RW1;
  logic [XLEN-1:0]     DIN0;
  logic [XLEN-1:0]     DIN1;
  logic                RSV;
  logic [AW-1:0]       RSV_ADDR;

  modport master (
    output RA, WE0, WE1, RW0, RW1, DIN0, DIN1, RSV, RSV_ADDR,
    input  DO, BUSY
  );

  modport slave (
    input  RA, WE0, WE1, RW0, RW1, DIN0, DIN1, RSV, RSV_ADDR,
    output DO, BUSY
  );
endinterface

// File: rtl/regfile_mp_read_port.sv
// One combinational read port: storage mux, optional same-cycle write forwarding,
// and the scoreboard bit of the addressed register.
module rf_read_port
  import regfile_mp_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = aw_of(NREG)
) (
  input  logic [AW-1:0]        ra_i,
  input  logic [NREG*XLEN-1:0] regs_flat_i,
  input  logic [NREG-1:0]      busy_i,
  input  logic                 we0_i,
  input  logic [AW-1:0]        rw0_i,
  input  logic [XLEN-1:0]      din0_i,
  input  logic                 we1_i,
  input  logic [AW-1:0]        rw1_i,
  input  logic [XLEN-1:0]      din1_i,
  output logic [XLEN-1:0]      do_o,
  output logic                 busy_o
);

  // Write enables arrive already qualified (reset, r0), so forwarding needs no extra gating.
  always_comb begin
    do_o = regs_flat_i[int'(ra_i)*XLEN +: XLEN];
    if (BYPASS != 0) begin
      if (we0_i && (rw0_i == ra_i)) do_o = din0_i;
      if (we1_i && (rw1_i == ra_i)) do_o = din1_i;
    end
  end

  assign busy_o = busy_i[ra_i];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports
// (port 1 wins on collision) and an advisory busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic CLK,
  input  logic RST_N,
  regfile_mp_if.slave bus
);

  localparam int AW = aw_of(NREG);

  logic [XLEN-1:0]      regs_q [NREG];
  logic [NREG-1:0]      busy_q;
  logic [NREG-1:0]      busy_d;
  logic [NREG*XLEN-1:0] regs_flat;
  logic                 we0_ok;
  logic                 we1_ok;
  logic                 rsv_ok;

  // Writes to r0 are dropped when it is hardwired; nothing is accepted during reset.
  assign we0_ok = bus.WE0 && RST_N && !((ZERO_R0 != 0) && (bus.RW0 == '0));
  assign we1_ok = bus.WE1 && RST_N && !((ZERO_R0 != 0) && (bus.RW1 == '0));
  assign rsv_ok = bus.RSV && RST_N && !((ZERO_R0 != 0) && (bus.RSV_ADDR == '0));

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREG; i++) regs_flat[i*XLEN +: XLEN] = regs_q[i];
  end

  // A reserve applied after the write clears so a new producer keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (we0_ok) busy_d[bus.RW0] = 1'b0;
    if (we1_ok) busy_d[bus.RW1] = 1'b0;
    if (rsv_ok) busy_d[bus.RSV_ADDR] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (we0_ok) regs_q[bus.RW0] <= bus.DIN0;
      if (we1_ok) regs_q[bus.RW1] <= bus.DIN1;
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    rf_read_port #(
      .XLEN   (XLEN),
      .NREG   (NREG),
      .BYPASS (BYPASS)
    ) u_port (
      .ra_i        (bus.RA[g*AW +: AW]),
      .regs_flat_i (regs_flat),
      .busy_i      (busy_q),
      .we0_i       (we0_ok),
      .rw0_i       (bus.RW0),
      .din0_i      (bus.DIN0),
      .we1_i       (we1_ok),
      .rw1_i       (bus.RW1),
      .din1_i      (bus.DIN1),
      .do_o        (bus.DO[g*XLEN +: XLEN]),
      .busy_o      (bus.BUSY[g])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a forwarding instance and a non-forwarding
// instance share one stimulus stream.
module tb_regfile_mp;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;

  logic CLK;
  logic RST_N;
  int   n_chk;
  int   n_fail;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();
  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus_nb ();

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1), .ZERO_R0(1)) u_dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0), .ZERO_R0(1)) u_dut_nb (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus_nb.slave)
  );

  assign bus_nb.RA       = bus.RA;
  assign bus_nb.WE0      = bus.WE0;
  assign bus_nb.WE1      = bus.WE1;
  assign bus_nb.RW0      = bus.RW0;
  assign bus_nb.RW1      = bus.RW1;
  assign bus_nb.DIN0     = bus.DIN0;
  assign bus_nb.DIN1     = bus.DIN1;
  assign bus_nb.RSV      = bus.RSV;
  assign bus_nb.RSV_ADDR = bus.RSV_ADDR;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.WE0 = 1'b0; bus.WE1 = 1'b0;
    bus.RW0 = '0;   bus.RW1 = '0;
    bus.DIN0 = '0;  bus.DIN1 = '0;
    bus.RSV = 1'b0; bus.RSV_ADDR = '0;
  endtask

  function automatic logic [63:0] do0(input logic [NRD*XLEN-1:0] v);
    return v[63:0];
  endfunction

  function automatic logic [63:0] do1(input logic [NRD*XLEN-1:0] v);
    return v[127:64];
  endfunction

  initial begin
    n_chk = 0;
    n_fail = 0;
    idle();
    bus.RA = '0;
    RST_N = 1'b0;
    #12;
    chk("reset_do", {32'd0, bus.DO[63:32] | bus.DO[31:0]}, 64'd0);
    chk("reset_busy", {62'd0, bus.BUSY}, 64'd0);
    RST_N = 1'b1;
    tick();

    // Write r1 then read it back next cycle.
    bus.WE0 = 1'b1; bus.RW0 = 5'd1; bus.DIN0 = 64'd234;
    tick();
    idle();
    bus.RA[4:0] = 5'd1;
    #1;
    chk("r1_read", do0(bus.DO), 64'd234);
    chk("r1_read_nb", do0(bus_nb.DO), 64'd234);

    // Same-cycle forwarding on read port 1.
    bus.WE0 = 1'b1; bus.RW0 = 5'd18; bus.DIN0 = 64'd672; bus.RA[9:5] = 5'd18;
    #1;
    chk("byp_do1", do1(bus.DO), 64'd672);
    chk("nobyp_do1", do1(bus_nb.DO), 64'd0);
    tick();
    idle();
    #1;
    chk("r18_after", do1(bus.DO), 64'd672);
    chk("r18_after_nb", do1(bus_nb.DO), 64'd672);

    // Write collision: port 1 wins in storage and in forwarding.
    bus.WE0 = 1'b1; bus.WE1 = 1'b1; bus.RW0 = 5'd5; bus.RW1 = 5'd5;
    bus.DIN0 = 64'd11; bus.DIN1 = 64'd22; bus.RA[4:0] = 5'd5;
    #1;
    chk("coll_byp", do0(bus.DO), 64'd22);
    chk("coll_nb_pre", do0(bus_nb.DO), 64'd0);
    tick();
    idle();
    #1;
    chk("coll_reg5", do0(bus.DO), 64'd22);
    chk("coll_reg5_nb", do0(bus_nb.DO), 64'd22);

    // Independent writes on both ports to different registers.
    bus.WE0 = 1'b1; bus.RW0 = 5'd3; bus.DIN0 = 64'hA5A5_0000_0000_0003;
    bus.WE1 = 1'b1; bus.RW1 = 5'd4; bus.DIN1 = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    idle();
    bus.RA[4:0] = 5'd3; bus.RA[9:5] = 5'd4;
    #1;
    chk("dual_r3", do0(bus.DO), 64'hA5A5_0000_0000_0003);
    chk("dual_r4", do1(bus.DO), 64'hFFFF_FFFF_FFFF_FFFF);

    // Register 0 is hardwired: no write, no forward, no busy.
    bus.WE0 = 1'b1; bus.RW0 = 5'd0; bus.DIN0 = 64'd99; bus.RA[4:0] = 5'd0;
    #1;
    chk("r0_nobyp", do0(bus.DO), 64'd0);
    tick();
    idle();
    #1;
    chk("r0_read", do0(bus.DO), 64'd0);
    bus.RSV = 1'b1; bus.RSV_ADDR = 5'd0;
    tick();
    idle();
    #1;
    chk("r0_busy", {63'd0, bus.BUSY[0]}, 64'd0);

    // Scoreboard on register 7.
    bus.RA[9:5] = 5'd7;
    bus.RSV = 1'b1; bus.RSV_ADDR = 5'd7;
    #1;
    chk("rsv_no_byp", {63'd0, bus.BUSY[1]}, 64'd0);
    tick();
    idle();
    #1;
    chk("rsv_set", {63'd0, bus.BUSY[1]}, 64'd1);
    bus.RSV = 1'b1; bus.RSV_ADDR = 5'd7;
    tick();
    idle();
    #1;
    chk("rsv_again", {63'd0, bus.BUSY[1]}, 64'd1);
    bus.WE1 = 1'b1; bus.RW1 = 5'd7; bus.DIN1 = 64'd5;
    bus.RSV = 1'b1; bus.RSV_ADDR = 5'd7;
    tick();
    idle();
    #1;
    chk("rsv_wins", {63'd0, bus.BUSY[1]}, 64'd1);
    chk("rsv_wr_data", do1(bus.DO), 64'd5);
    bus.WE1 = 1'b1; bus.RW1 = 5'd7; bus.DIN1 = 64'd6;
    #1;
    chk("busy_reg_only", {63'd0, bus.BUSY[1]}, 64'd1);
    tick();
    idle();
    #1;
    chk("wr_clears", {63'd0, bus.BUSY[1]}, 64'd0);
    chk("wr_r7", do1(bus.DO), 64'd6);

    // Load r1..r3, reserve r2, then reset mid-cycle.
    bus.WE0 = 1'b1; bus.RW0 = 5'd1; bus.DIN0 = 64'h11;
    bus.WE1 = 1'b1; bus.RW1 = 5'd2; bus.DIN1 = 64'h22;
    tick();
    idle();
    bus.WE0 = 1'b1; bus.RW0 = 5'd3; bus.DIN0 = 64'h33;
    bus.RSV = 1'b1; bus.RSV_ADDR = 5'd2;
    tick();
    idle();
    bus.RA[4:0] = 5'd3; bus.RA[9:5] = 5'd2;
    #1;
    chk("pre_rst_r3", do0(bus.DO), 64'h33);
    chk("pre_rst_r2", do1(bus.DO), 64'h22);
    chk("pre_rst_busy", {63'd0, bus.BUSY[1]}, 64'd1);
    #1;
    RST_N = 1'b0;
    #1;
    chk("rst_do0", do0(bus.DO), 64'd0);
    chk("rst_do1", do1(bus.DO), 64'd0);
    chk("rst_busy", {62'd0, bus.BUSY}, 64'd0);
    bus.WE0 = 1'b1; bus.RW0 = 5'd3; bus.DIN0 = 64'h44;
    bus.RSV = 1'b1; bus.RSV_ADDR = 5'd2;
    tick();
    idle();
    #1;
    chk("rst_ignore_wr", do0(bus.DO), 64'd0);
    chk("rst_ignore_rsv", {62'd0, bus.BUSY}, 64'd0);
    #2;
    RST_N = 1'b1;
    bus.WE0 = 1'b1; bus.RW0 = 5'd3; bus.DIN0 = 64'h55;
    tick();
    idle();
    #1;
    chk("resume_wr", do0(bus.DO), 64'h55);
    chk("resume_r2", do1(bus.DO), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
